axi_master_traffic_gen: RTL and testbench
=========================================

# axi_master_traffic_gen

Parametrised AXI4 master that replaces the all-zero tie-off master on an unused interconnect port. It can stay silent or generate self-checking traffic: incrementing-pattern write bursts, read-back bursts compared against the same pattern, or both in sequence. It sits on any master slot of the AXI interconnect and is used for bring-up and interconnect/slave verification. With mode 0 it is electrically identical to a tie-off master.

## Interface
Parameters:
- ID_WIDTH, 2, width of all ID fields
- DATA_WIDTH, 32, data bus width (32 or 64); STRB width = DATA_WIDTH/8
- TX_ID, 0, ID driven on AW/AR and expected on B/R
- BURST_LEN, 15, AXI LEN value (beats-1), 0..255
- NUM_BURSTS, 4, bursts per phase, 1..65535

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run (sampled only in IDLE)
- mode  in  2  0 silent, 1 write, 2 read-check, 3 write then read-check
- base_addr  in  32  address of first burst
- seed  in  DATA_WIDTH  pattern seed
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- err_count  out  16  saturating error count for the last run
- MASTER_CLK  out  1  = clk
- MASTER_RSTN  out  1  = ~rst
- MASTER_WR_ADDR_ID/ADDR/LEN/BURST/VALID  out  ID_WIDTH/32/8/2/1; MASTER_WR_ADDR_READY in 1
- MASTER_WR_DATA/STRB/DATA_LAST/DATA_VALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1; MASTER_WR_DATA_READY in 1
- MASTER_WR_BACK_ID/RESP/VALID  in  ID_WIDTH/2/1; MASTER_WR_BACK_READY out 1
- MASTER_RD_ADDR_ID/ADDR/LEN/BURST/VALID  out  ID_WIDTH/32/8/2/1; MASTER_RD_ADDR_READY in 1
- MASTER_RD_BACK_ID/RD_DATA/RD_DATA_RESP/RD_DATA_LAST/RD_DATA_VALID  in  ID_WIDTH/DATA_WIDTH/2/1/1; MASTER_RD_DATA_READY out 1

## Operation
- States: IDLE, WA, WD, WB, RA, RD, FIN.
- IDLE: `start` with mode 0 goes to FIN. Mode 1 or 3 goes to WA. Mode 2 goes to RA. Accepting `start` clears `err_count` and the burst/beat counters.
- WA: AWVALID=1 until the AW handshake, then go to WD.
- WD: WVALID=1. Each W handshake increments the beat counter. WLAST=1 on beat BURST_LEN; its handshake goes to WB.
- WB: BREADY=1. On the B handshake, count one error if BRESP≠0 and one if BID≠TX_ID. Then go to WA if more bursts remain; otherwise go to RA for mode 3, or FIN.
- RA: ARVALID=1 until the AR handshake, then go to RD.
- RD: RREADY=1. Each R handshake compares RDATA with the expected pattern word. Per beat, count at most one error if any of these holds: data mismatch, RRESP≠0, RID≠TX_ID, or RLAST≠(beat==BURST_LEN).
  - The burst ends on the beat counter, not on RLAST.
  - Then go to RA if more bursts remain, else FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Fixed fields:
  - AWBURST=ARBURST=2'b01 (INCR); AWLEN=ARLEN=BURST_LEN.
  - AWID=ARID=TX_ID; WSTRB all ones.
- Address of burst b = base_addr + b*(BURST_LEN+1)*(DATA_WIDTH/8), modulo 2^32. No 4 KB splitting.
- Pattern word for burst b, beat k = seed + b*(BURST_LEN+1) + k, truncated to DATA_WIDTH. The read phase restarts at b=0 with the same seed.
- Only one transaction is outstanding; no W before AW.
- `err_count` saturates at 0xFFFF and holds its value until the next accepted `start`.
- `busy`=1 in every state except IDLE.
- `start` during busy is ignored.
- `mode`, `base_addr` and `seed` are latched at `start`.

## Timing
- Reset values:
  - All VALID/READY/LAST outputs = 0; all address, data, ID, LEN, BURST and STRB outputs = 0.
  - busy=0, done=0, err_count=0, state IDLE.
- Reset mid-run: next cycle all outputs return to reset values; the outstanding transaction is abandoned.
- `start` sampled in cycle N: AWVALID or ARVALID is high in N+1. For mode 0, `done` is high in N+1.
- VALID stays high with stable payload until READY. Payload is registered and changes only after a handshake.
- WVALID rises the cycle after the AW handshake and can stream one beat per cycle.
- BREADY/RREADY are high for the whole of WB/RD and are registered, never combinational on VALID.
- `done` is high the cycle after the final B or R handshake.
- In IDLE all AXI outputs are 0.

## Test plan
- Reset then mode 0 `start`: no AXI VALID ever asserts; `done` pulses in the next cycle; err_count=0.
- Mode 1, base 0x1000, seed 0xA5000000, BURST_LEN=3, NUM_BURSTS=2, against an always-ready memory model:
  - AW addresses are 0x1000 and 0x1010.
  - Data is 0xA5000000..0xA5000007 with WLAST on beats 3 and 7.
  - done, err_count=0.
- Mode 3 with the same parameters and random READY/VALID stalls: read-back matches; err_count=0; VALID payloads are stable during every stall.
- Mode 2 where the slave corrupts beat 2 and returns RRESP=2 on the same beat: err_count=1.
- Mode 2 with RLAST missing on the final beat and RID≠TX_ID on one other beat: err_count=2.
- Assert rst during WD beat 1: all outputs are at reset values the next cycle; a subsequent mode 1 start completes normally.

Source files
------------

// File: rtl/axi_master_traffic_gen.sv
// AXI4 master traffic generator: silent tie-off, incrementing-pattern write bursts,
// read-back bursts checked against the same pattern, or write followed by read-check.
module axi_master_traffic_gen #(
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TX_ID      = 0,
  parameter int BURST_LEN  = 15,
  parameter int NUM_BURSTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [31:0]             base_addr,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_count,
  output logic                    MASTER_CLK,
  output logic                    MASTER_RSTN,
  output logic [ID_WIDTH-1:0]     MASTER_WR_ADDR_ID,
  output logic [31:0]             MASTER_WR_ADDR,
  output logic [7:0]              MASTER_WR_ADDR_LEN,
  output logic [1:0]              MASTER_WR_ADDR_BURST,
  output logic                    MASTER_WR_ADDR_VALID,
  input  logic                    MASTER_WR_ADDR_READY,
  output logic [DATA_WIDTH-1:0]   MASTER_WR_DATA,
  output logic [DATA_WIDTH/8-1:0] MASTER_WR_STRB,
  output logic                    MASTER_WR_DATA_LAST,
  output logic                    MASTER_WR_DATA_VALID,
  input  logic                    MASTER_WR_DATA_READY,
  input  logic [ID_WIDTH-1:0]     MASTER_WR_BACK_ID,
  input  logic [1:0]              MASTER_WR_BACK_RESP,
  input  logic                    MASTER_WR_BACK_VALID,
  output logic                    MASTER_WR_BACK_READY,
  output logic [ID_WIDTH-1:0]     MASTER_RD_ADDR_ID,
  output logic [31:0]             MASTER_RD_ADDR,
  output logic [7:0]              MASTER_RD_ADDR_LEN,
  output logic [1:0]              MASTER_RD_ADDR_BURST,
  output logic                    MASTER_RD_ADDR_VALID,
  input  logic                    MASTER_RD_ADDR_READY,
  input  logic [ID_WIDTH-1:0]     MASTER_RD_BACK_ID,
  input  logic [DATA_WIDTH-1:0]   MASTER_RD_DATA,
  input  logic [1:0]              MASTER_RD_DATA_RESP,
  input  logic                    MASTER_RD_DATA_LAST,
  input  logic                    MASTER_RD_DATA_VALID,
  output logic                    MASTER_RD_DATA_READY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WA   = 3'd1;
  localparam logic [2:0] S_WD   = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_RA   = 3'd4;
  localparam logic [2:0] S_RD   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam logic [31:0]         STRIDE     = 32'((BURST_LEN + 1) * (DATA_WIDTH / 8));
  localparam logic [7:0]          LAST_BEAT  = 8'(BURST_LEN);
  localparam logic [15:0]         LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [ID_WIDTH-1:0] ID_VAL     = ID_WIDTH'(TX_ID);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  logic [2:0]            state;
  logic [1:0]            mode_q;
  logic [31:0]           base_q, addr_q, aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] seed_q, pat_q, w_data;
  logic [15:0]           burst_cnt, err_q;
  logic [7:0]            beat_cnt;
  logic                  active_q, done_q;
  logic                  aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;

  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       more_bursts, last_beat, r_bad;
  logic [1:0] b_errs;

  assign aw_hs       = aw_valid & MASTER_WR_ADDR_READY;
  assign w_hs        = w_valid & MASTER_WR_DATA_READY;
  assign b_hs        = b_ready & MASTER_WR_BACK_VALID;
  assign ar_hs       = ar_valid & MASTER_RD_ADDR_READY;
  assign r_hs        = r_ready & MASTER_RD_DATA_VALID;
  assign more_bursts = (burst_cnt != LAST_BURST);
  assign last_beat   = (beat_cnt == LAST_BEAT);
  assign b_errs      = {1'b0, MASTER_WR_BACK_RESP != 2'b00} + {1'b0, MASTER_WR_BACK_ID != ID_VAL};
  assign r_bad       = (MASTER_RD_DATA != pat_q) || (MASTER_RD_DATA_RESP != 2'b00) ||
                       (MASTER_RD_BACK_ID != ID_VAL) || (MASTER_RD_DATA_LAST != last_beat);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // NOTE: all state updates use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      seed_q    <= '0;
      pat_q     <= '0;
      w_data    <= '0;
      burst_cnt <= '0;
      err_q     <= '0;
      beat_cnt  <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      b_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q    <= mode;
          base_q    <= base_addr;
          seed_q    <= seed;
          addr_q    <= base_addr;
          pat_q     <= seed;
          burst_cnt <= '0;
          beat_cnt  <= '0;
          err_q     <= '0;
          active_q  <= (mode != 2'd0);
          case (mode)
            2'd0:    begin state <= S_FIN; done_q <= 1'b1; end
            2'd2:    begin state <= S_RA;  ar_valid <= 1'b1; ar_addr <= base_addr; end
            default: begin state <= S_WA;  aw_valid <= 1'b1; aw_addr <= base_addr; end
          endcase
        end
        S_WA: if (aw_hs) begin
          aw_valid <= 1'b0;
          aw_addr  <= '0;
          w_valid  <= 1'b1;
          w_data   <= pat_q;
          w_last   <= (LAST_BEAT == 8'd0);
          beat_cnt <= '0;
          state    <= S_WD;
        end
        S_WD: if (w_hs) begin
          pat_q <= pat_q + ONE;
          if (w_last) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            w_data  <= '0;
            b_ready <= 1'b1;
            state   <= S_WB;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            w_data   <= pat_q + ONE;
            w_last   <= ((beat_cnt + 8'd1) == LAST_BEAT);
          end
        end
        S_WB: if (b_hs) begin
          b_ready <= 1'b0;
          err_q   <= sat_add(err_q, b_errs);
          if (more_bursts) begin
            burst_cnt <= burst_cnt + 16'd1;
            addr_q    <= addr_q + STRIDE;
            aw_addr   <= addr_q + STRIDE;
            aw_valid  <= 1'b1;
            state     <= S_WA;
          end else if (mode_q == 2'd3) begin
            // Read phase replays the write pattern from the first burst.
            burst_cnt <= '0;
            addr_q    <= base_q;
            pat_q     <= seed_q;
            ar_addr   <= base_q;
            ar_valid  <= 1'b1;
            state     <= S_RA;
          end else begin
            done_q <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_RA: if (ar_hs) begin
          ar_valid <= 1'b0;
          ar_addr  <= '0;
          r_ready  <= 1'b1;
          beat_cnt <= '0;
          state    <= S_RD;
        end
        S_RD: if (r_hs) begin
          pat_q <= pat_q + ONE;
          if (r_bad) err_q <= sat_add(err_q, 2'd1);
          // The burst ends on our own beat count; a missing RLAST is an error, not a hang.
          if (last_beat) begin
            r_ready  <= 1'b0;
            beat_cnt <= '0;
            if (more_bursts) begin
              burst_cnt <= burst_cnt + 16'd1;
              addr_q    <= addr_q + STRIDE;
              ar_addr   <= addr_q + STRIDE;
              ar_valid  <= 1'b1;
              state     <= S_RA;
            end else begin
              done_q <= 1'b1;
              state  <= S_FIN;
            end
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        S_FIN: begin
          active_q <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err_count = err_q;

  assign MASTER_CLK  = clk;
  assign MASTER_RSTN = ~rst;

  // Constant fields are gated so an idle or silent master drives all-zero like a tie-off.
  assign MASTER_WR_ADDR_ID    = active_q ? ID_VAL : '0;
  assign MASTER_WR_ADDR       = aw_addr;
  assign MASTER_WR_ADDR_LEN   = active_q ? LAST_BEAT : '0;
  assign MASTER_WR_ADDR_BURST = active_q ? 2'b01 : 2'b00;
  assign MASTER_WR_ADDR_VALID = aw_valid;
  assign MASTER_WR_DATA       = w_data;
  assign MASTER_WR_STRB       = active_q ? '1 : '0;
  assign MASTER_WR_DATA_LAST  = w_last;
  assign MASTER_WR_DATA_VALID = w_valid;
  assign MASTER_WR_BACK_READY = b_ready;
  assign MASTER_RD_ADDR_ID    = active_q ? ID_VAL : '0;
  assign MASTER_RD_ADDR       = ar_addr;
  assign MASTER_RD_ADDR_LEN   = active_q ? LAST_BEAT : '0;
  assign MASTER_RD_ADDR_BURST = active_q ? 2'b01 : 2'b00;
  assign MASTER_RD_ADDR_VALID = ar_valid;
  assign MASTER_RD_DATA_READY = r_ready;

endmodule

// File: tb/tb_axi_master_traffic_gen.sv
// Self-checking bench: randomly stalling AXI slave with a memory, fault injection on R,
// and a pattern/address reference model derived from the burst arithmetic.
module tb_axi_master_traffic_gen;
  localparam int IDW   = 2;
  localparam int DW    = 32;
  localparam int TXID  = 0;
  localparam int L     = 3;
  localparam int NB    = 2;
  localparam int BEATS = NB * (L + 1);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [31:0] base_addr = '0;
  logic [DW-1:0] seed = '0;
  logic busy, done, m_clk, m_rstn;
  logic [15:0] err_count;

  logic [IDW-1:0] aw_id, ar_id, b_id = '0, r_id = '0;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [1:0] aw_burst, ar_burst, b_resp = '0, r_resp = '0;
  logic aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
  logic aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0, ar_ready = 1'b0;
  logic r_valid = 1'b0, r_last = 1'b0;
  logic [DW-1:0] w_data, r_data = '0;
  logic [DW/8-1:0] w_strb;

  axi_master_traffic_gen #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .TX_ID(TXID),
                           .BURST_LEN(L), .NUM_BURSTS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .seed(seed),
    .busy(busy), .done(done), .err_count(err_count),
    .MASTER_CLK(m_clk), .MASTER_RSTN(m_rstn),
    .MASTER_WR_ADDR_ID(aw_id), .MASTER_WR_ADDR(aw_addr), .MASTER_WR_ADDR_LEN(aw_len),
    .MASTER_WR_ADDR_BURST(aw_burst), .MASTER_WR_ADDR_VALID(aw_valid), .MASTER_WR_ADDR_READY(aw_ready),
    .MASTER_WR_DATA(w_data), .MASTER_WR_STRB(w_strb), .MASTER_WR_DATA_LAST(w_last),
    .MASTER_WR_DATA_VALID(w_valid), .MASTER_WR_DATA_READY(w_ready),
    .MASTER_WR_BACK_ID(b_id), .MASTER_WR_BACK_RESP(b_resp), .MASTER_WR_BACK_VALID(b_valid),
    .MASTER_WR_BACK_READY(b_ready),
    .MASTER_RD_ADDR_ID(ar_id), .MASTER_RD_ADDR(ar_addr), .MASTER_RD_ADDR_LEN(ar_len),
    .MASTER_RD_ADDR_BURST(ar_burst), .MASTER_RD_ADDR_VALID(ar_valid), .MASTER_RD_ADDR_READY(ar_ready),
    .MASTER_RD_BACK_ID(r_id), .MASTER_RD_DATA(r_data), .MASTER_RD_DATA_RESP(r_resp),
    .MASTER_RD_DATA_LAST(r_last), .MASTER_RD_DATA_VALID(r_valid), .MASTER_RD_DATA_READY(r_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and run bookkeeping
  logic [31:0]   run_base = '0;
  logic [DW-1:0] run_seed = '0;
  int aw_count = 0, w_count = 0, ar_count = 0, r_count = 0, last_hs_cyc = 0;
  bit any_valid = 1'b0, stall = 1'b0;
  int f_data = -1, f_resp = -1, f_rlast = -1, f_rid = -1;
  logic [31:0]   aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [DW-1:0] mem [logic [31:0]];

  function automatic logic [31:0] exp_addr(input int b);
    return run_base + 32'(b * (L + 1) * (DW / 8));
  endfunction

  function automatic logic [DW-1:0] exp_word(input int g);
    return run_seed + DW'(g);
  endfunction

  function automatic int exp_errs();
    int e = 0;
    for (int g = 0; g < BEATS; g++)
      if (g == f_data || g == f_resp || g == f_rlast || g == f_rid) e++;
    return e;
  endfunction

  function automatic bit go();
    return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  function automatic logic any_axi_out();
    return |{aw_id, aw_addr, aw_len, aw_burst, aw_valid, w_data, w_strb, w_last, w_valid,
             b_ready, ar_id, ar_addr, ar_len, ar_burst, ar_valid, r_ready};
  endfunction

  // Slave: decides READY/VALID on the falling edge, then records the handshakes the next rising edge will take.
  initial begin : slave
    bit w_allowed, b_pend, b_drop, r_active, r_drop, aw_hold, w_hold, ar_hold;
    int r_k;
    logic [31:0] r_addr, w_addr, aw_prev, ar_prev;
    logic [DW:0] w_prev;
    forever begin
      @(negedge clk);
      if (rst) begin
        {w_allowed, b_pend, b_drop, r_active, r_drop, aw_hold, w_hold, ar_hold} = '0;
        {aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last} = '0;
        continue;
      end
      if (aw_hold) check("aw_stable", {aw_valid, aw_addr}, {1'b1, aw_prev});
      if (w_hold)  check("w_stable", {w_valid, w_last, w_data}, {1'b1, w_prev});
      if (ar_hold) check("ar_stable", {ar_valid, ar_addr}, {1'b1, ar_prev});
      if (w_valid) check("w_after_aw", w_allowed, 1);
      if (aw_valid || w_valid || ar_valid) any_valid = 1'b1;

      if (b_drop) begin b_valid = 1'b0; b_drop = 1'b0; end
      if (b_pend && !b_valid && go()) begin
        b_valid = 1'b1; b_id = IDW'(TXID); b_resp = 2'b00;
      end
      if (r_drop) begin r_valid = 1'b0; r_drop = 1'b0; end
      if (r_active && !r_valid && go()) begin
        r_data = mem.exists(r_addr) ? mem[r_addr] : '0;
        if (r_count == f_data) r_data = r_data ^ DW'(1);
        r_resp  = (r_count == f_resp) ? 2'b10 : 2'b00;
        r_id    = (r_count == f_rid) ? IDW'(TXID + 1) : IDW'(TXID);
        r_last  = (r_k == L) ^ (r_count == f_rlast);
        r_valid = 1'b1;
      end
      aw_ready = go();
      w_ready  = go();
      ar_ready = go();

      aw_hold = aw_valid && !aw_ready; aw_prev = aw_addr;
      w_hold  = w_valid && !w_ready;   w_prev  = {w_last, w_data};
      ar_hold = ar_valid && !ar_ready; ar_prev = ar_addr;

      if (aw_valid && aw_ready) begin
        check("aw_addr", aw_addr, exp_addr(aw_count));
        check("aw_fields", {aw_id, aw_len, aw_burst}, {IDW'(TXID), 8'(L), 2'b01});
        aw_log.push_back(aw_addr);
        aw_count++;
        w_addr = aw_addr;
        w_allowed = 1'b1;
      end
      if (w_valid && w_ready) begin
        check("w_data", w_data, exp_word(w_count));
        check("w_last", w_last, (w_count % (L + 1)) == L);
        check("w_strb", w_strb, {(DW/8){1'b1}});
        mem[w_addr] = w_data;
        w_addr = w_addr + 32'(DW / 8);
        w_log.push_back(w_data);
        w_count++;
        if (w_last) begin w_allowed = 1'b0; b_pend = 1'b1; end
      end
      if (b_valid && b_ready) begin
        b_pend = 1'b0; b_drop = 1'b1; last_hs_cyc = cyc;
      end
      if (ar_valid && ar_ready) begin
        check("ar_addr", ar_addr, exp_addr(ar_count));
        check("ar_fields", {ar_id, ar_len, ar_burst}, {IDW'(TXID), 8'(L), 2'b01});
        ar_count++;
        r_active = 1'b1; r_addr = ar_addr; r_k = 0;
      end
      if (r_valid && r_ready) begin
        r_drop = 1'b1; last_hs_cyc = cyc;
        r_count++; r_k++;
        r_addr = r_addr + 32'(DW / 8);
        if (r_k > L) r_active = 1'b0;
      end
    end
  end

  task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [DW-1:0] s,
                     input bit st, input string tag);
    int exp_e, n;
    bit got;
    run_base = b; run_seed = s; stall = st;
    aw_count = 0; w_count = 0; ar_count = 0; r_count = 0; any_valid = 1'b0;
    aw_log.delete(); w_log.delete();
    exp_e = (m == 2'd2) ? exp_errs() : 0;
    if (m == 2'd2)
      for (int g = 0; g < BEATS; g++)
        mem[exp_addr(g / (L + 1)) + 32'((g % (L + 1)) * (DW / 8))] = exp_word(g);
    @(negedge clk);
    start = 1'b1; mode = m; base_addr = b; seed = s;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); base_addr = $urandom; seed = DW'($urandom);
    check({tag, "_busy_n1"}, busy, 1);
    case (m)
      2'd0:    check({tag, "_done_n1"}, done, 1);
      2'd2:    check({tag, "_arvalid_n1"}, ar_valid, 1);
      default: check({tag, "_awvalid_n1"}, aw_valid, 1);
    endcase
    got = 1'b0; n = 0;
    while (!got && n < 3000) begin
      if (done) got = 1'b1;
      else begin
        // A start while busy must be ignored.
        start = (n == 4);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    if (m != 2'd0) check({tag, "_done_latency"}, cyc, last_hs_cyc + 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_err_count"}, err_count, exp_e);
    check({tag, "_aw_count"}, aw_count, m[0] ? NB : 0);
    check({tag, "_w_count"}, w_count, m[0] ? BEATS : 0);
    check({tag, "_ar_count"}, ar_count, m[1] ? NB : 0);
    check({tag, "_r_count"}, r_count, m[1] ? BEATS : 0);
    check({tag, "_any_valid"}, any_valid, m != 2'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_axi_zero"}, any_axi_out(), 0);
    check({tag, "_err_hold"}, err_count, exp_e);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [31:0]   a0, a1;
    logic [DW-1:0] d0, d7;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_axi_zero", any_axi_out(), 0);
    check("rst_rstn", m_rstn, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstn_release", m_rstn, 1);

    run(2'd0, 32'h1000, 32'hA500_0000, 1'b0, "silent");

    run(2'd1, 32'h1000, 32'hA500_0000, 1'b0, "write");
    a0 = aw_log[0]; a1 = aw_log[1]; d0 = w_log[0]; d7 = w_log[7];
    check("write_aw0", a0, 32'h0000_1000);
    check("write_aw1", a1, 32'h0000_1010);
    check("write_d0", d0, 32'hA500_0000);
    check("write_d7", d7, 32'hA500_0007);

    run(2'd3, 32'h1000, 32'hA500_0000, 1'b1, "wr_rd_stall");
    for (int i = 0; i < 3; i++)
      run(2'd3, $urandom, DW'($urandom), 1'b1, "wr_rd_rand");
    run(2'd3, 32'hFFFF_FFF0, DW'($urandom), 1'b1, "wr_rd_wrap");

    f_data = 2; f_resp = 2;
    run(2'd2, 32'h1000, 32'hA500_0000, 1'b1, "rd_corrupt");
    f_data = -1; f_resp = -1;

    f_rlast = BEATS - 1; f_rid = 1;
    run(2'd2, 32'h1000, 32'hA500_0000, 1'b1, "rd_rlast_rid");
    f_rlast = -1; f_rid = -1;

    f_data = int'($urandom_range(0, BEATS - 1));
    f_rid  = int'($urandom_range(0, BEATS - 1));
    f_rlast = int'($urandom_range(0, BEATS - 1));
    run(2'd2, $urandom, DW'($urandom), 1'b1, "rd_rand_faults");
    f_data = -1; f_rid = -1; f_rlast = -1;

    // Reset while beat 1 of the first write burst is on the bus.
    run_base = 32'h2000; run_seed = 32'h1234_5678; stall = 1'b0;
    aw_count = 0; w_count = 0; ar_count = 0; r_count = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'd1; base_addr = 32'h2000; seed = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    #1;
    n = 0;
    while (!(w_valid && w_data == exp_word(1)) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("rst_mid_reach_beat1", w_valid && (w_data == exp_word(1)), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err_count, 0);
    check("rst_mid_axi_zero", any_axi_out(), 0);
    rst = 1'b0;
    run(2'd1, 32'h2000, 32'h1234_5678, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
